// File: rtl/eventually_window_checker.sv
// eventually_window_checker
// Hardware checker for the property "after req, ack eventually arrives within [MIN_DLY:MAX_DLY]
// cycles" (MAX_DLY = 0 means no upper bound). It gives an emulation/FPGA run the verdict that an
// SVA eventually / s_eventually would give in simulation.
//
// Ports
//   clk        in   1      single clock, posedge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   1      starts an obligation
//   ack        in   1      awaited event
//   eot        in   1      end-of-test strobe; resolves a pending obligation
//   busy       out  1      obligation pending
//   elapsed    out  CW     edges since the current obligation was accepted (saturating)
//   pass       out  1      1-cycle pulse: ack inside the window
//   fail       out  1      1-cycle pulse: obligation violated
//   fail_code  out  2      01 EARLY, 10 TIMEOUT, 11 UNRESOLVED; held until the next fail
//   req_drop   out  1      1-cycle pulse: req ignored because an obligation is pending
//   pass_cnt   out  CNT_W  saturating pass count
//   fail_cnt   out  CNT_W  saturating fail count
module eventually_window_checker #(
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 5,
    parameter int unsigned STRONG  = 1,
    parameter int unsigned CW      = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             ack,
    input  logic             eot,
    output logic             busy,
    output logic [CW-1:0]    elapsed,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic             req_drop,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    if (MIN_DLY == 0) begin : g_bad_min
        $error("eventually_window_checker: MIN_DLY must be >= 1");
    end
    if (MAX_DLY != 0 && MAX_DLY < MIN_DLY) begin : g_bad_max
        $error("eventually_window_checker: MAX_DLY must be 0 or >= MIN_DLY");
    end

    typedef enum logic [1:0] {StIdle, StWait, StWindow} state_e;

    localparam logic [1:0]  CodeEarly   = 2'b01;
    localparam logic [1:0]  CodeTimeout = 2'b10;
    localparam logic [1:0]  CodeUnres   = 2'b11;
    localparam bit          Bounded     = (MAX_DLY != 0);
    localparam logic [CW:0] MinK        = (CW+1)'(MIN_DLY);
    localparam logic [CW:0] MaxK        = (CW+1)'(MAX_DLY);
    localparam logic [CW:0] ElSat       = {1'b0, {CW{1'b1}}};

    state_e             state_q, state_d;
    logic [CW-1:0]      elapsed_q, elapsed_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [1:0]         code_q, code_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CW:0]        k;
    logic               done;
    logic               accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            elapsed_q  <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            code_q     <= 2'b00;
            drop_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            elapsed_q  <= elapsed_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            drop_q     <= drop_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Next-state logic. k is the edge index of the current edge relative to acceptance.
    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        code_d    = code_q;
        drop_d    = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        k         = {1'b0, elapsed_q} + (CW+1)'(1);

        if (state_q != StIdle) begin
            // ack outranks timeout and eot on the same edge
            if (ack) begin
                done = 1'b1;
                if (k < MinK) begin
                    fail_d = 1'b1;
                    code_d = CodeEarly;
                end else begin
                    pass_d = 1'b1;
                end
            end else if (Bounded && k >= MaxK) begin
                done   = 1'b1;
                fail_d = 1'b1;
                code_d = CodeTimeout;
            end else if (eot) begin
                done = 1'b1;
                if (STRONG != 0) begin
                    fail_d = 1'b1;
                    code_d = CodeUnres;
                end
            end

            if (done) begin
                state_d = StIdle;
                accept  = req;
            end else begin
                elapsed_d = (k > ElSat) ? ElSat[CW-1:0] : k[CW-1:0];
                drop_d    = req;
                // State reflects whether the next edge falls inside the window
                state_d   = (k + (CW+1)'(1) >= MinK) ? StWindow : StWait;
            end
        end else begin
            accept = req;
        end

        if (accept) begin
            elapsed_d = '0;
            state_d   = (MIN_DLY == 1) ? StWindow : StWait;
        end

        pass_cnt_d = (pass_d && pass_cnt_q != '1) ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
        fail_cnt_d = (fail_d && fail_cnt_q != '1) ? fail_cnt_q + CNT_W'(1) : fail_cnt_q;
    end

    // Outputs
    always_comb begin
        busy      = (state_q != StIdle);
        elapsed   = elapsed_q;
        pass      = pass_q;
        fail      = fail_q;
        fail_code = code_q;
        req_drop  = drop_q;
        pass_cnt  = pass_cnt_q;
        fail_cnt  = fail_cnt_q;
    end

endmodule

// File: tb/tb_eventually_window_checker.sv
module tb_eventually_window_checker;

    localparam int N = 3;

    // Instance 0: MIN=2 MAX=5 strong; 1: MIN=1 unbounded strong; 2: MIN=1 unbounded weak
    function automatic int min_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int max_of(input int i);
        return (i == 0) ? 5 : 0;
    endfunction
    function automatic bit strong_of(input int i);
        return (i != 2);
    endfunction

    logic clk = 1'b0;
    logic rst_n, req, ack, eot;
    always #5 clk = ~clk;

    logic        o_busy [N];
    logic        o_pass [N];
    logic        o_fail [N];
    logic        o_drop [N];
    logic [1:0]  o_code [N];
    logic [7:0]  o_el   [N];
    logic [15:0] o_pc   [N];
    logic [15:0] o_fc   [N];

    eventually_window_checker #(.MIN_DLY(2), .MAX_DLY(5), .STRONG(1), .CW(8), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .eot(eot),
        .busy(o_busy[0]), .elapsed(o_el[0]), .pass(o_pass[0]), .fail(o_fail[0]),
        .fail_code(o_code[0]), .req_drop(o_drop[0]), .pass_cnt(o_pc[0]), .fail_cnt(o_fc[0])
    );
    eventually_window_checker #(.MIN_DLY(1), .MAX_DLY(0), .STRONG(1), .CW(8), .CNT_W(16)) u_us (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .eot(eot),
        .busy(o_busy[1]), .elapsed(o_el[1]), .pass(o_pass[1]), .fail(o_fail[1]),
        .fail_code(o_code[1]), .req_drop(o_drop[1]), .pass_cnt(o_pc[1]), .fail_cnt(o_fc[1])
    );
    eventually_window_checker #(.MIN_DLY(1), .MAX_DLY(0), .STRONG(0), .CW(8), .CNT_W(16)) u_uw (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .eot(eot),
        .busy(o_busy[2]), .elapsed(o_el[2]), .pass(o_pass[2]), .fail(o_fail[2]),
        .fail_code(o_code[2]), .req_drop(o_drop[2]), .pass_cnt(o_pc[2]), .fail_cnt(o_fc[2])
    );

    // Reference model: an obligation is remembered by the cycle number it was accepted on.
    int       cyc;
    bit       m_pend [N];
    int       m_acc  [N];
    int       m_el   [N];
    bit [1:0] m_code [N];
    int       m_pc   [N];
    int       m_fc   [N];
    bit       m_p    [N];
    bit       m_f    [N];
    bit       m_d    [N];
    int       checks;
    int       errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_acc[i] = 0; m_el[i] = 0; m_code[i] = 0;
            m_pc[i] = 0; m_fc[i] = 0; m_p[i] = 0; m_f[i] = 0; m_d[i] = 0;
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < N; i++) begin
            bit was  = m_pend[i];
            bit done = 0;
            int k    = cyc - m_acc[i];
            m_p[i] = 0; m_f[i] = 0; m_d[i] = 0;
            if (was) begin
                if (ack) begin
                    done = 1;
                    if (k < min_of(i)) begin m_f[i] = 1; m_code[i] = 2'b01; end
                    else m_p[i] = 1;
                end else if (max_of(i) != 0 && k >= max_of(i)) begin
                    done = 1; m_f[i] = 1; m_code[i] = 2'b10;
                end else if (eot) begin
                    done = 1;
                    if (strong_of(i)) begin m_f[i] = 1; m_code[i] = 2'b11; end
                end
                if (done) m_pend[i] = 0;
                else begin
                    m_el[i] = (k > 255) ? 255 : k;
                    m_d[i]  = req;
                end
            end
            if (req && (!was || done)) begin
                m_pend[i] = 1; m_acc[i] = cyc; m_el[i] = 0;
            end
            if (m_p[i] && m_pc[i] < 65535) m_pc[i]++;
            if (m_f[i] && m_fc[i] < 65535) m_fc[i]++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.u%0d.busy", tag, i), 32'(o_busy[i]), 32'(m_pend[i]));
            chk($sformatf("%s.u%0d.elapsed", tag, i), 32'(o_el[i]), 32'(m_el[i]));
            chk($sformatf("%s.u%0d.pass", tag, i), 32'(o_pass[i]), 32'(m_p[i]));
            chk($sformatf("%s.u%0d.fail", tag, i), 32'(o_fail[i]), 32'(m_f[i]));
            chk($sformatf("%s.u%0d.code", tag, i), 32'(o_code[i]), 32'(m_code[i]));
            chk($sformatf("%s.u%0d.drop", tag, i), 32'(o_drop[i]), 32'(m_d[i]));
            chk($sformatf("%s.u%0d.pcnt", tag, i), 32'(o_pc[i]), 32'(m_pc[i]));
            chk($sformatf("%s.u%0d.fcnt", tag, i), 32'(o_fc[i]), 32'(m_fc[i]));
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic a, input logic e, input string tag);
        req = r; ack = a; eot = e;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; req = 1'b0; ack = 1'b0; eot = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pass inside the window
        step(1, 0, 0, "t1_req");
        step(0, 0, 0, "t1_k1");
        step(0, 0, 0, "t1_k2");
        step(0, 1, 0, "t1_ack");
        chk("t1_pass", 32'(o_pass[0]), 32'd1);
        chk("t1_pcnt", 32'(o_pc[0]), 32'd1);
        step(0, 0, 0, "t1_after");
        chk("t1_busy_low", 32'(o_busy[0]), 32'd0);

        // Early ack
        step(1, 0, 0, "t2_req");
        step(0, 1, 0, "t2_ack");
        chk("t2_fail", 32'(o_fail[0]), 32'd1);
        chk("t2_code", 32'(o_code[0]), 32'd1);
        chk("t2_fcnt", 32'(o_fc[0]), 32'd1);

        // Timeout, then a late ack produces nothing
        step(1, 0, 0, "t3_req");
        for (int j = 1; j < 5; j++) step(0, 0, 0, "t3_wait");
        step(0, 0, 0, "t3_k5");
        chk("t3_fail", 32'(o_fail[0]), 32'd1);
        chk("t3_code", 32'(o_code[0]), 32'd2);
        step(0, 1, 0, "t3_late");
        chk("t3_late_pass", 32'(o_pass[0]), 32'd0);
        chk("t3_late_fail", 32'(o_fail[0]), 32'd0);

        // Unbounded obligation resolved by eot after 20 cycles
        step(1, 0, 0, "t4_req");
        for (int j = 1; j < 20; j++) step(0, 0, 0, "t4_wait");
        step(0, 0, 1, "t4_eot");
        chk("t4_strong_fail", 32'(o_fail[1]), 32'd1);
        chk("t4_strong_code", 32'(o_code[1]), 32'd3);
        chk("t4_strong_el", 32'(o_el[1]), 32'd19);
        chk("t4_weak_fail", 32'(o_fail[2]), 32'd0);
        chk("t4_weak_busy", 32'(o_busy[2]), 32'd0);

        // Dropped req, then back-to-back pass + new obligation
        step(1, 0, 0, "t5_req");
        step(0, 0, 0, "t5_k1");
        step(1, 0, 0, "t5_k2");
        chk("t5_drop", 32'(o_drop[0]), 32'd1);
        step(0, 0, 0, "t5_k3");
        step(1, 1, 0, "t5_k4");
        chk("t5_pass", 32'(o_pass[0]), 32'd1);
        chk("t5_el0", 32'(o_el[0]), 32'd0);
        chk("t5_busy", 32'(o_busy[0]), 32'd1);
        chk("t5_nodrop", 32'(o_drop[0]), 32'd0);
        step(0, 0, 0, "t5_n1");
        step(0, 0, 0, "t5_n2");
        step(0, 1, 0, "t5_n3");

        // Asynchronous reset mid-obligation
        step(1, 0, 0, "t6_req");
        step(0, 0, 0, "t6_k1");
        step(0, 0, 0, "t6_k2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst");
        chk("t6_rst_busy", 32'(o_busy[0]), 32'd0);
        chk("t6_rst_pcnt", 32'(o_pc[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) step(0, 0, 0, "t6_post");
        chk("t6_fcnt", 32'(o_fc[0]), 32'd0);

        // Elapsed saturates in unbounded mode
        step(1, 0, 0, "t7_req");
        for (int j = 0; j < 300; j++) step(0, 0, 0, "t7_wait");
        chk("t7_sat", 32'(o_el[1]), 32'd255);
        step(0, 1, 0, "t7_ack");

        // Randomized traffic
        for (int j = 0; j < 1500; j++) begin
            step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 5) == 0),
                 logic'($urandom_range(0, 39) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
